// File: rtl/mant_div_iter.sv
// Iterative restoring mantissa divider: BITS_PER_CYC quotient bits per clock,
// with divide-by-zero and quotient-overflow short cuts and a valid/ack result handshake.
module mant_div_iter #(
  parameter int MANT_W       = 24,
  parameter int BITS_PER_CYC = 1
) (
  input  logic                in_clk,
  input  logic                in_rst,
  input  logic                in_start,
  input  logic [2*MANT_W-3:0] in_dividend,
  input  logic [MANT_W-1:0]   in_divisor,
  input  logic                in_ack,
  output logic                out_ready,
  output logic                out_valid,
  output logic [MANT_W-1:0]   out_quotient,
  output logic [2*MANT_W-3:0] out_remainder,
  output logic                out_sticky,
  output logic                out_dz,
  output logic                out_ovf
);

  localparam int          N     = MANT_W / BITS_PER_CYC;
  localparam int          DW    = 2*MANT_W - 2;
  localparam int          XW    = 2*MANT_W;
  localparam int          CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned BPC   = BITS_PER_CYC;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [MANT_W-1:0] div_q;
  logic              accept;
  logic              div_zero;
  logic              ovf_det;
  logic              special;
  logic [DW-1:0]     rem_step;
  logic [MANT_W-1:0] q_step;
  logic [XW-1:0]     shifted;
  int unsigned       bit_idx;

  assign div_zero = (in_divisor == '0);
  assign ovf_det  = ({2'b00, in_dividend} >= ({{MANT_W{1'b0}}, in_divisor} << MANT_W));
  assign special  = div_zero | ovf_det;
  assign accept   = in_start & out_ready;

  always_ff @(posedge in_clk) begin
    if (in_rst) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (accept) begin
      state_nx = special ? DONE : RUN;
    end else begin
      case (state)
        IDLE:    state_nx = IDLE;
        RUN:     if (cnt == '0) state_nx = DONE;
        DONE:    if (in_ack) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    out_ready  = (state == IDLE) || ((state == DONE) && in_ack);
    out_valid  = (state == DONE);
    out_sticky = |out_remainder;
  end

  // Compare at full 2*MANT_W width; the subtract itself can be narrow because
  // it only happens when the shifted divisor is not larger than the remainder.
  always_comb begin
    rem_step = out_remainder;
    q_step   = out_quotient;
    shifted  = '0;
    bit_idx  = 0;
    for (int unsigned j = 0; j < BPC; j++) begin
      bit_idx = 32'(cnt) * BPC + (BPC - 1 - j);
      shifted = {{MANT_W{1'b0}}, div_q} << bit_idx;
      if ({2'b00, rem_step} >= shifted) begin
        rem_step = rem_step - shifted[DW-1:0];
        q_step   = q_step | (MANT_W'(1) << bit_idx);
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      cnt           <= '0;
      div_q         <= '0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_dz        <= 1'b0;
      out_ovf       <= 1'b0;
    end else if (accept) begin
      cnt           <= CNT_W'(N - 1);
      div_q         <= in_divisor;
      out_remainder <= in_dividend;
      out_quotient  <= special ? '1 : '0;
      out_dz        <= div_zero;
      out_ovf       <= ~div_zero & ovf_det;
    end else if (state == RUN) begin
      out_remainder <= rem_step;
      out_quotient  <= q_step;
      if (cnt != '0) cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mant_div_iter.sv
// Directed bench for mant_div_iter: default instance (1 bit/cycle) and a 4 bits/cycle instance.
module tb_mant_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        s1, a1, s4, a4;
  logic [45:0] dd1, dd4;
  logic [23:0] dv1, dv4;
  logic        r1, v1, st1, dz1, ov1, r4, v4, st4, dz4, ov4;
  logic [23:0] q1, q4;
  logic [45:0] rm1, rm4;

  int cur = 1;
  int n_chk = 0;
  int n_fail = 0;

  logic        m_ready, m_valid, m_sticky, m_dz, m_ovf;
  logic [23:0] m_q;
  logic [45:0] m_r;

  always #5 clk = ~clk;

  mant_div_iter dut1 (
    .in_clk(clk), .in_rst(rst), .in_start(s1), .in_dividend(dd1), .in_divisor(dv1),
    .in_ack(a1), .out_ready(r1), .out_valid(v1), .out_quotient(q1), .out_remainder(rm1),
    .out_sticky(st1), .out_dz(dz1), .out_ovf(ov1)
  );

  mant_div_iter #(.MANT_W(24), .BITS_PER_CYC(4)) dut4 (
    .in_clk(clk), .in_rst(rst), .in_start(s4), .in_dividend(dd4), .in_divisor(dv4),
    .in_ack(a4), .out_ready(r4), .out_valid(v4), .out_quotient(q4), .out_remainder(rm4),
    .out_sticky(st4), .out_dz(dz4), .out_ovf(ov4)
  );

  assign m_ready  = (cur == 4) ? r4  : r1;
  assign m_valid  = (cur == 4) ? v4  : v1;
  assign m_q      = (cur == 4) ? q4  : q1;
  assign m_r      = (cur == 4) ? rm4 : rm1;
  assign m_sticky = (cur == 4) ? st4 : st1;
  assign m_dz     = (cur == 4) ? dz4 : dz1;
  assign m_ovf    = (cur == 4) ? ov4 : ov1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic st, input logic [45:0] dd, input logic [23:0] dv, input logic ak);
    if (cur == 4) begin
      s4 = st; dd4 = dd; dv4 = dv; a4 = ak;
    end else begin
      s1 = st; dd1 = dd; dv1 = dv; a1 = ak;
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_ready"},  64'(m_ready),  64'd1);
    chk({tag, "_valid"},  64'(m_valid),  64'd0);
    chk({tag, "_q"},      64'(m_q),      64'd0);
    chk({tag, "_r"},      64'(m_r),      64'd0);
    chk({tag, "_sticky"}, 64'(m_sticky), 64'd0);
    chk({tag, "_dz"},     64'(m_dz),     64'd0);
    chk({tag, "_ovf"},    64'(m_ovf),    64'd0);
  endtask

  // Issue one operation (back-to-back via ack if a result is pending) and check it.
  task automatic op(input logic [45:0] dd, input logic [23:0] dv, input int lat,
                    input logic [23:0] eq, input logic [45:0] er, input logic edz,
                    input logic eovf, input bit noise, input bit keep, input string tag);
    int edges;
    @(negedge clk);
    drv(1'b1, dd, dv, m_valid);
    #1;
    chk({tag, "_ready_at_accept"}, 64'(m_ready), 64'd1);
    @(posedge clk); #1;
    if (noise) drv(1'b1, '1, 24'd1, 1'b0);
    else       drv(1'b0, '0, '0, 1'b0);
    edges = 1;
    while (!m_valid && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    drv(1'b0, '0, '0, 1'b0);
    chk({tag, "_latency"}, 64'(edges), 64'(lat));
    chk({tag, "_q"},       64'(m_q),      64'(eq));
    chk({tag, "_r"},       64'(m_r),      64'(er));
    chk({tag, "_sticky"},  64'(m_sticky), 64'(er != '0));
    chk({tag, "_dz"},      64'(m_dz),     64'(edz));
    chk({tag, "_ovf"},     64'(m_ovf),    64'(eovf));
    if (!keep) begin
      @(negedge clk);
      drv(1'b0, '0, '0, 1'b1);
      @(posedge clk); #1;
      drv(1'b0, '0, '0, 1'b0);
      chk({tag, "_valid_drop"}, 64'(m_valid), 64'd0);
      chk({tag, "_q_retained"}, 64'(m_q), 64'(eq));
    end
  endtask

  initial begin
    int vcount;
    rst = 1'b1;
    s1 = 0; a1 = 0; dd1 = '0; dv1 = '0;
    s4 = 0; a4 = 0; dd4 = '0; dv4 = '0;
    repeat (2) @(posedge clk);
    #1;
    cur = 1; #0 chk_idle_zero("rst1");
    cur = 4; #0 chk_idle_zero("rst4");
    @(negedge clk);
    rst = 1'b0;

    cur = 1;
    op(46'h2000_0000_0000, 24'h800000, 25, 24'h400000, 46'd0, 0, 0, 0, 0, "pow2");
    op(46'd100, 24'd7, 25, 24'd14, 46'd2, 0, 0, 0, 1, "d100_7");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drv(1'b1, 46'h1, 24'h1, 1'b0);
      @(posedge clk); #1;
      chk("hold_valid", 64'(m_valid), 64'd1);
      chk("hold_ready", 64'(m_ready), 64'd0);
      chk("hold_q",     64'(m_q),     64'd14);
      chk("hold_r",     64'(m_r),     64'd2);
    end
    @(negedge clk);
    drv(1'b0, '0, '0, 1'b1);
    @(posedge clk); #1;
    drv(1'b0, '0, '0, 1'b0);
    chk("hold_release", 64'(m_valid), 64'd0);
    chk("idle_ready",   64'(m_ready), 64'd1);

    op(46'h1234, 24'd0, 1, 24'hFFFFFF, 46'h1234, 1, 0, 0, 0, "dz");
    op(46'h3FFF_FFFF_FFFF, 24'd1, 1, 24'hFFFFFF, 46'h3FFF_FFFF_FFFF, 0, 1, 0, 0, "ovf_max");
    op(46'h100_0000, 24'd1, 1, 24'hFFFFFF, 46'h100_0000, 0, 1, 0, 0, "ovf_edge");
    op(46'hFF_FFFF, 24'd1, 25, 24'hFFFFFF, 46'd0, 0, 0, 0, 0, "fit_edge");
    op(46'h3FFF_FFFF_FFFF, 24'hFFFFFF, 25, 24'h400000, 46'h3FFFFF, 0, 0, 0, 0, "max_div");
    op(46'hF4240, 24'hC00000, 25, 24'd0, 46'hF4240, 0, 0, 0, 0, "q_zero");

    // Reset lands during the 10th RUN cycle.
    @(negedge clk);
    drv(1'b1, 46'd100, 24'd7, 1'b0);
    @(posedge clk); #1;
    drv(1'b0, '0, '0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_idle_zero("abort");
    vcount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (m_valid) vcount++;
    end
    chk("abort_no_valid", 64'(vcount), 64'd0);

    cur = 4;
    op(46'd100, 24'd7, 7, 24'd14, 46'd2, 0, 0, 0, 1, "b4_a");
    op(46'h2000_0000_0000, 24'h800000, 7, 24'h400000, 46'd0, 0, 0, 1, 1, "b4_b");
    op(46'h1234, 24'd0, 1, 24'hFFFFFF, 46'h1234, 1, 0, 0, 1, "b4_dz");
    op(46'h3FFF_FFFF_FFFF, 24'hFFFFFF, 7, 24'h400000, 46'h3FFFFF, 0, 0, 0, 0, "b4_c");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mant_div_iter.md
MANT_DIV_ITER -- requirements
Module: mant_div_iter

Interface
REQ-001 SHALL have parameter MANT_W, default 24: mantissa/divisor width incl. hidden bit.
REQ-002 SHALL have parameter BITS_PER_CYC, default 1: quotient bits resolved per cycle; legal 1, 2, 4, SHALL divide MANT_W.
REQ-003 in_clk  input  1  sole clock, rising edge.
REQ-004 in_rst  input  1  reset, synchronous, active-high.
REQ-005 in_start  input  1  request; accepted when in_start & out_ready.
REQ-006 in_dividend  input  2*MANT_W-2  dividend.
REQ-007 in_divisor  input  MANT_W  divisor.
REQ-008 in_ack  input  1  consumer takes result while out_valid=1.
REQ-009 out_ready  output  1  high only in IDLE, or in DONE while in_ack=1.
REQ-010 out_valid  output  1  result valid; high only in DONE.
REQ-011 out_quotient  output  MANT_W  quotient.
REQ-012 out_remainder  output  2*MANT_W-2  remainder.
REQ-013 out_sticky  output  1  OR-reduction of out_remainder.
REQ-014 out_dz  output  1  divisor was zero.
REQ-015 out_ovf  output  1  quotient did not fit in MANT_W bits.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; N = MANT_W/BITS_PER_CYC.
REQ-017 Accept edge SHALL register in_dividend (into remainder register), in_divisor, clear quotient and flags; inputs otherwise ignored until next accept.
REQ-018 On accept: divisor==0 -> DONE, out_dz=1, quotient all ones, remainder=dividend.
REQ-019 On accept: divisor!=0 and dividend >= divisor<<MANT_W (full-width compare) -> DONE, out_ovf=1, quotient all ones, remainder=dividend.
REQ-020 Otherwise accept -> RUN, iteration counter loaded with N-1.
REQ-021 Each RUN cycle SHALL do BITS_PER_CYC restoring steps, bit i from MANT_W-1 down to 0: trial=rem-(divisor<<i); trial>=0 -> q[i]=1, rem=trial; else q[i]=0, rem unchanged.
REQ-022 Internal subtract SHALL be 2*MANT_W bits wide; no truncation of divisor<<i.
REQ-023 RUN with counter==0 SHALL go to DONE; else counter decrements.
REQ-024 Result SHALL satisfy dividend = quotient*divisor + remainder, remainder < divisor, whenever dz=ovf=0.
REQ-025 Latency: out_valid SHALL rise N+1 edges after the accept edge (accept edge counts 1); special cases (REQ-018/019) 1 edge.
REQ-026 DONE SHALL hold out_valid and all result outputs stable until in_ack=1.
REQ-027 DONE with in_ack=1 and in_start=0 -> IDLE, out_valid low next cycle.
REQ-028 DONE with in_ack=1 and in_start=1 -> new operation accepted same edge (back-to-back, no idle bubble).
REQ-029 in_start during RUN or DONE without in_ack SHALL be ignored, no state change.
REQ-030 in_ack while out_valid=0 SHALL have no effect.
REQ-031 Result outputs outside DONE SHALL retain last values; only out_valid qualifies them.

Reset
REQ-032 in_rst=1 at an edge SHALL force IDLE, out_ready=1, out_valid=0, out_quotient=0, out_remainder=0, out_sticky=0, out_dz=0, out_ovf=0, counter=0.
REQ-033 Reset SHALL take priority over in_start/in_ack and abort RUN/DONE; aborted operation SHALL never produce out_valid.

Verification
REQ-034 Defaults: dividend 0x2000_0000_0000, divisor 0x800000 -> quotient 0x400000, remainder 0, sticky 0, dz=ovf=0, out_valid exactly 25 edges after accept.
REQ-035 Defaults: dividend 100, divisor 7 -> quotient 14, remainder 2, sticky 1; hold in_ack=0 for 10 cycles -> outputs stable, out_ready=0.
REQ-036 Divisor 0, dividend 0x1234 -> out_dz=1, quotient 0xFFFFFF, remainder 0x1234, valid after 1 edge; dividend 0x3FFF_FFFF_FFFF, divisor 1 -> out_ovf=1, quotient 0xFFFFFF.
REQ-037 in_rst pulsed during 10th RUN cycle -> next cycle IDLE, out_ready=1, all outputs 0, no out_valid ever for that op.
REQ-038 BITS_PER_CYC=4: back-to-back ops via in_ack&in_start in DONE -> each valid 7 edges after accept, results equal BITS_PER_CYC=1 run; in_start during RUN ignored.
REQ-039 Random 10k ops per legal BITS_PER_CYC vs reference model -> REQ-024 identity holds, flags correct.
